text_ram_arbiter: RTL and testbench

TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

---
 rtl/text_pkg.sv | 32 +++
 rtl/text_word_merge.sv | 27 ++
 rtl/text_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_text_ram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants for the text-mode character RAM: screen geometry defaults,
// cell field positions inside a 32-bit word, the blank cell and the writer FSM states.
package text_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;
    localparam int DEF_AW   = 12;

    localparam int ODD_CHAR_LSB  = 24;
    localparam int ODD_FG_LSB    = 21;
    localparam int ODD_BG_LSB    = 18;
    localparam int EVEN_CHAR_LSB = 10;
    localparam int EVEN_FG_LSB   = 7;
    localparam int EVEN_BG_LSB   = 4;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [2:0] BLANK_FG   = 3'd7;
    localparam logic [2:0] BLANK_BG   = 3'd0;

    // Both cells blank, low nibble cleared.
    localparam logic [31:0] BLANK_WORD = {BLANK_CHAR, BLANK_FG, BLANK_BG,
                                          BLANK_CHAR, BLANK_FG, BLANK_BG, 4'h0};

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        CLR
    } state_e;

endpackage

// File: rtl/text_word_merge.sv
// Replaces one character cell inside a RAM word, leaving the sibling cell and
// the low nibble untouched.
module text_word_merge
    import text_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic        parity_i,
    input  logic [7:0]  char_i,
    input  logic [2:0]  fg_i,
    input  logic [2:0]  bg_i,
    output logic [31:0] new_word_o
);

    always_comb begin
        new_word_o = old_word_i;
        if (parity_i) begin
            new_word_o[ODD_CHAR_LSB +: 8] = char_i;
            new_word_o[ODD_FG_LSB   +: 3] = fg_i;
            new_word_o[ODD_BG_LSB   +: 3] = bg_i;
        end else begin
            new_word_o[EVEN_CHAR_LSB +: 8] = char_i;
            new_word_o[EVEN_FG_LSB   +: 3] = fg_i;
            new_word_o[EVEN_BG_LSB   +: 3] = bg_i;
        end
    end

endmodule

// File: rtl/text_ram_arbiter.sv
// Shares a single-port text RAM between the display reader (always first) and a
// character writer doing read-modify-write, plus a full-screen clear engine.
module text_ram_arbiter
    import text_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int AW   = DEF_AW
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [6:0]    wr_col,
    input  logic [4:0]    wr_row,
    input  logic [7:0]    wr_char,
    input  logic [2:0]    wr_fg,
    input  logic [2:0]    wr_bg,
    input  logic          clr_start,
    output logic          busy,
    output logic          err
);

    localparam logic [31:0]   COLS_U    = 32'(COLS);
    localparam logic [31:0]   ROWS_U    = 32'(ROWS);
    localparam logic [AW-1:0] LAST_WORD = AW'((COLS * ROWS) / 2 - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic          parity_q, parity_d;
    logic [7:0]    char_q, char_d;
    logic [2:0]    fg_q, fg_d;
    logic [2:0]    bg_q, bg_d;
    logic [31:0]   merged_q, merged_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          in_range;
    logic [AW-1:0] cell_idx;
    logic [31:0]   merge_word;

    assign in_range = ({25'd0, wr_col} < COLS_U) && ({27'd0, wr_row} < ROWS_U);
    assign cell_idx = AW'(wr_col) + AW'(wr_row) * AW'(COLS);

    assign wr_ready = !rst && (state_q == IDLE) && !clr_start;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

    text_word_merge u_merge (
        .old_word_i (ram_rdata),
        .parity_i   (parity_q),
        .char_i     (char_q),
        .fg_i       (fg_q),
        .bg_i       (bg_q),
        .new_word_o (merge_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            parity_q <= 1'b0;
            char_q   <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            merged_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            parity_q <= parity_d;
            char_q   <= char_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            merged_q <= merged_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // The display owns the bus by default; only RD, WR and CLR steal it, and
    // only in cycles where the display is not asking.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        parity_d  = parity_q;
        char_d    = char_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        merged_d  = merged_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        ram_addr  = disp_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLR;
                    cnt_d   = '0;
                end else if (wr_valid) begin
                    if (in_range) begin
                        word_d   = cell_idx >> 1;
                        parity_d = cell_idx[0];
                        char_d   = wr_char;
                        fg_d     = wr_fg;
                        bg_d     = wr_bg;
                        state_d  = RD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (!disp_req) begin
                    ram_addr = word_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                merged_d = merge_word;
                state_d  = WR;
            end
            WR: begin
                if (!disp_req) begin
                    ram_we    = 1'b1;
                    ram_addr  = word_q;
                    ram_wdata = merged_q;
                    state_d   = IDLE;
                end
            end
            CLR: begin
                if (!disp_req) begin
                    ram_we    = 1'b1;
                    ram_addr  = cnt_q;
                    ram_wdata = BLANK_WORD;
                    if (cnt_q == LAST_WORD) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Scoreboard bench for text_ram_arbiter: a behavioural RAM, an arithmetic cell
// model feeding an expected-write queue, and a monitor that checks every RAM cycle.
module tb_text_ram_arbiter;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          wr_valid;
    logic          wr_ready;
    logic [6:0]    wr_col;
    logic [4:0]    wr_row;
    logic [7:0]    wr_char;
    logic [2:0]    wr_fg;
    logic [2:0]    wr_bg;
    logic          clr_start;
    logic          busy;
    logic          err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mem[WORDS];
    logic [31:0] modelMem[WORDS];
    logic        memInit;
    logic        randDisp;
    int          holdCnt;
    int          testsRun;
    int          testsFailed;
    int          errSeen;
    int          errExpected;

    text_ram_arbiter #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_char   (wr_char),
        .wr_fg     (wr_fg),
        .wr_bg     (wr_bg),
        .clr_start (clr_start),
        .busy      (busy),
        .err       (err)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] initVal(int i);
        if (i == 82) return 32'h12345678;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Cell replacement expressed as plain arithmetic on the word value.
    function automatic logic [31:0] cellModel(logic [31:0] old, bit odd,
                                              logic [7:0] ch, logic [2:0] fg, logic [2:0] bg);
        longint unsigned o, r;
        o = longint'(old);
        if (odd)
            r = ch * 2**24 + fg * 2**21 + bg * 2**18 + (o % 2**18);
        else
            r = (o / 2**18) * 2**18 + ch * 2**10 + fg * 2**7 + bg * 2**4 + (o % 16);
        return r[31:0];
    endfunction

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= initVal(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: bus ownership every cycle, and every RAM write against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (disp_req) begin
                checkOutput("dispAddr", 32'(ram_addr), 32'(disp_addr));
                checkOutput("dispNoWe", 32'(ram_we), 32'd0);
            end else if (!busy) begin
                checkOutput("idleAddr", 32'(ram_addr), 32'(disp_addr));
            end
            if (ram_we) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousWe", 32'(ram_we), 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("wrAddr", 32'(ram_addr), 32'(e.addr));
                    checkOutput("wrData", ram_wdata, e.data);
                end
            end
            if (err) errSeen++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (holdCnt > 0) begin
            disp_req  = 1'b1;
            disp_addr = AW'($urandom);
            holdCnt--;
        end else if (randDisp) begin
            disp_req  = ($urandom_range(0, 3) == 0);
            disp_addr = AW'($urandom);
        end else begin
            disp_req = 1'b0;
        end
    endtask

    function automatic bit modelWrite(int col, int row, logic [7:0] ch, logic [2:0] fg, logic [2:0] bg);
        int   idx;
        exp_t e;
        if (col >= COLS || row >= ROWS) return 1'b0;
        idx = col + row * COLS;
        e.addr = AW'(idx / 2);
        e.data = cellModel(modelMem[idx / 2], (idx % 2) == 1, ch, fg, bg);
        modelMem[idx / 2] = e.data;
        expQ.push_back(e);
        return 1'b1;
    endfunction

    // Entered and left at a falling edge; lat is the write cycle after the handshake edge.
    task automatic applyStimulus(input int col, input int row, input logic [7:0] ch,
                                 input logic [2:0] fg, input logic [2:0] bg,
                                 input int hold, output int lat);
        bit ok;
        lat = -1;
        ok = modelWrite(col, row, ch, fg, bg);
        if (!ok) errExpected++;
        wr_col   = 7'(col);
        wr_row   = 5'(row);
        wr_char  = ch;
        wr_fg    = fg;
        wr_bg    = bg;
        wr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (wr_ready) break;
            tick();
            @(negedge clk);
        end
        checkOutput("wrReadyWait", 32'(wr_ready), 32'd1);
        holdCnt = hold;
        tick();
        wr_valid = 1'b0;
        if (ok) begin
            for (int k = 1; k <= 100; k++) begin
                @(negedge clk);
                if (ram_we) begin
                    lat = k;
                    break;
                end
                tick();
            end
            checkOutput("writeSeen", 32'(ram_we), 32'd1);
            tick();
            @(negedge clk);
            checkOutput("readyAfterWrite", 32'(wr_ready), 32'd1);
        end else begin
            @(negedge clk);
            checkOutput("errPulse", 32'(err), 32'd1);
            checkOutput("errReady", 32'(wr_ready), 32'd1);
            checkOutput("errBusy", 32'(busy), 32'd0);
            tick();
            @(negedge clk);
            checkOutput("errOneCycle", 32'(err), 32'd0);
        end
    endtask

    task automatic runClear;
        exp_t e;
        clr_start = 1'b1;
        wr_col    = 7'd1;
        wr_row    = 5'd1;
        wr_valid  = 1'b1;
        @(negedge clk);
        checkOutput("clrBlocksReady", 32'(wr_ready), 32'd0);
        for (int i = 0; i < COLS * ROWS / 2; i++) begin
            e.addr = AW'(i);
            e.data = 32'h20 * 2**24 + 7 * 2**21 + 32'h20 * 2**10 + 7 * 2**7;
            modelMem[i] = e.data;
            expQ.push_back(e);
        end
        tick();
        repeat (5) tick();
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy) break;
            tick();
        end
        checkOutput("clearDone", 32'(busy), 32'd0);
        checkOutput("clearCount", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] saved;
        testsRun    = 0;
        testsFailed = 0;
        errSeen     = 0;
        errExpected = 0;
        holdCnt     = 0;
        randDisp    = 1'b0;
        memInit     = 1'b1;
        rst         = 1'b1;
        disp_req    = 1'b0;
        disp_addr   = '0;
        wr_valid    = 1'b0;
        wr_col      = '0;
        wr_row      = '0;
        wr_char     = '0;
        wr_fg       = '0;
        wr_bg       = '0;
        clr_start   = 1'b0;
        for (int i = 0; i < WORDS; i++) modelMem[i] = initVal(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", 32'(wr_ready), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstWe", 32'(ram_we), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        memInit = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterRst", 32'(wr_ready), 32'd1);

        $display("[TB] directed writes");
        applyStimulus(5, 2, 8'h41, 3'd7, 3'd1, 0, lat);
        checkOutput("latencyMin", 32'(lat), 32'd3);
        applyStimulus(5, 2, 8'h41, 3'd7, 3'd1, 10, lat);
        checkOutput("latencyHeld", 32'(lat), 32'd13);
        applyStimulus(0, 0, 8'h5A, 3'd2, 3'd5, 0, lat);
        checkOutput("latencyEven", 32'(lat), 32'd3);
        applyStimulus(79, 29, 8'hFF, 3'd3, 3'd6, 0, lat);
        checkOutput("latencyLast", 32'(lat), 32'd3);
        applyStimulus(80, 0, 8'h11, 3'd1, 3'd1, 0, lat);
        applyStimulus(0, 30, 8'h22, 3'd2, 3'd2, 0, lat);
        applyStimulus(127, 31, 8'h33, 3'd3, 3'd3, 0, lat);

        $display("[TB] reset during read-modify-write");
        saved = modelMem[41];
        void'(modelWrite(3, 1, 8'h77, 3'd4, 3'd2));
        wr_col   = 7'd3;
        wr_row   = 5'd1;
        wr_char  = 8'h77;
        wr_fg    = 3'd4;
        wr_bg    = 3'd2;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortReady", 32'(wr_ready), 32'd0);
        checkOutput("abortWe", 32'(ram_we), 32'd0);
        void'(expQ.pop_back());
        modelMem[41] = saved;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterAbort", 32'(wr_ready), 32'd1);
        applyStimulus(3, 1, 8'h78, 3'd5, 3'd3, 0, lat);
        checkOutput("latencyAfterAbort", 32'(lat), 32'd3);

        $display("[TB] full clear with a simultaneous write request");
        runClear();

        $display("[TB] random writes with random display traffic");
        randDisp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            applyStimulus($urandom_range(0, 84), $urandom_range(0, 31), 8'($urandom),
                          3'($urandom), 3'($urandom), 0, lat);
        end
        runClear();
        for (int n = 0; n < 20; n++) begin
            applyStimulus($urandom_range(0, 79), $urandom_range(0, 29), 8'($urandom),
                          3'($urandom), 3'($urandom), 0, lat);
        end
        randDisp = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("errCount", 32'(errSeen), 32'(errExpected));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
